// File: rtl/adder_resp_checker.sv
// adder_resp_checker
//   Checks the response of a WIDTH-bit adder against a + b + cin. A start
//   pulse clears all results and begins a run; each valid sample is
//   compared and marked in a coverage bitmap indexed by {a,b,cin}. The run
//   ends (DONE) on the edge that registers the last uncovered vector.
//
//   Optional feature macro: CHK_STOP_ON_FAIL_EN. When defined, the first
//   mismatch moves the checker to HALT (done=1, pass=0) on the edge that
//   registers it. When undefined, HALT does not exist and mismatches are
//   only counted.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse: clear results, (re)start a run
//   vld            in   a/b/cin/s/cout sample valid
//   a, b           in   WIDTH-bit operands applied to the adder
//   cin            in   carry-in applied to the adder
//   s, cout        in   adder response under check
//   busy           out  run in progress
//   done           out  run finished (full coverage, or halted)
//   pass           out  done with zero mismatches
//   err_cnt        out  ERR_W-bit saturating mismatch count
//   first_fail_vld out  first_fail_vec holds a captured failure
//   first_fail_vec out  {a,b,cin} of the first mismatch in the run
module adder_resp_checker #(
    parameter int WIDTH = 1,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vld,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     s,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 first_fail_vld,
    output logic [2*WIDTH:0]     first_fail_vec
);

    localparam int VEC_W = 2*WIDTH + 1;
    localparam int COV_N = 1 << VEC_W;

`ifdef CHK_STOP_ON_FAIL_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t             state;
    logic [COV_N-1:0]   cov;

    logic [VEC_W-1:0]   vec;
    logic [WIDTH:0]     sum_exp;
    logic               mismatch;
    logic               sample;
    logic [COV_N-1:0]   cov_hit;
    logic [COV_N-1:0]   cov_upd;
    logic [ERR_W-1:0]   err_upd;

    // Count up, but stick at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    always_comb begin
        vec      = {a, b, cin};
        sum_exp  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        mismatch = (sum_exp != {cout, s});
        // start has priority: a sample coinciding with start is dropped.
        sample   = vld && !start && (state == RUN);
        cov_hit  = '0;
        cov_hit[vec] = 1'b1;
        cov_upd  = cov | cov_hit;
        err_upd  = mismatch ? sat_inc(err_cnt) : err_cnt;
    end

    // Single FSM register block; busy/done/pass are registered alongside
    // the state so they change on exactly the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            cov            <= '0;
        end else if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            cov            <= '0;
        end else if (sample) begin
            cov     <= cov_upd;
            err_cnt <= err_upd;
            if (mismatch && !first_fail_vld) begin
                first_fail_vld <= 1'b1;
                first_fail_vec <= vec;
            end
`ifdef CHK_STOP_ON_FAIL_EN
            if (mismatch) begin
                state <= HALT;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b0;
            end else if (&cov_upd) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_upd == '0);
            end
`else
            if (&cov_upd) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_upd == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_adder_resp_checker.sv
module tb_adder_resp_checker;

    localparam int WIDTH  = 1;
    localparam int ERR_W  = 8;
    localparam int VW     = 2*WIDTH + 1;
    localparam int NVEC   = 1 << VW;
    localparam int ERRMAX = (1 << ERR_W) - 1;
    localparam int SW     = 4 + ERR_W + VW;

    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_HALT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, vld, cin, cout;
    logic [WIDTH-1:0] a, b, s;
    logic             busy, done, pass, first_fail_vld;
    logic [ERR_W-1:0] err_cnt;
    logic [VW-1:0]    first_fail_vec;

    int checks   = 0;
    int failures = 0;

    // Reference model: run status, mismatch count, first failure, set of
    // vectors seen.
    int m_state;
    int m_err;
    bit m_ffv;
    int m_ffvec;
    bit m_seen[NVEC];

    adder_resp_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] obs();
        return {busy, done, pass, err_cnt, first_fail_vld, first_fail_vec};
    endfunction

    function automatic logic [SW-1:0] mdl();
        logic d;
        d = (m_state == M_DONE) || (m_state == M_HALT);
        return {m_state == M_RUN, d, d && (m_err == 0), ERR_W'(m_err), m_ffv, VW'(m_ffvec)};
    endfunction

    task automatic model_clear();
        m_err = 0; m_ffv = 0; m_ffvec = 0;
        for (int i = 0; i < NVEC; i++) m_seen[i] = 0;
    endtask

    function automatic bit all_seen();
        for (int i = 0; i < NVEC; i++) if (!m_seen[i]) return 0;
        return 1;
    endfunction

    // One clock cycle: drive at negedge, advance model at posedge, return #1 later.
    task automatic step(input bit st, input bit v, input int vec, input bit bad);
        int sum;
        int resp;
        @(negedge clk);
        start = st; vld = v;
        {a, b, cin} = VW'(vec);
        sum  = int'(a) + int'(b) + int'(cin);
        resp = bad ? (sum ^ int'($urandom_range(1, (1 << (WIDTH+1)) - 1))) : sum;
        {cout, s} = (WIDTH+1)'(resp);
        @(posedge clk);
        if (st) begin
            m_state = M_RUN;
            model_clear();
        end else if (v && m_state == M_RUN) begin
            if (bad) begin
                if (m_err < ERRMAX) m_err++;
                if (!m_ffv) begin m_ffv = 1; m_ffvec = vec; end
`ifdef CHK_STOP_ON_FAIL_EN
                m_state = M_HALT;
`endif
            end
            m_seen[vec] = 1;
            if (m_state == M_RUN && all_seen()) m_state = M_DONE;
        end
        #1;
    endtask

    task automatic shuffle(output int p[NVEC]);
        for (int i = 0; i < NVEC; i++) p[i] = i;
        for (int i = NVEC-1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; vld = 0; a = 0; b = 0; cin = 0; s = 0; cout = 0;
        m_state = M_IDLE; model_clear();
        #1;
        checks++;
        if (obs() !== {SW{1'b0}}) begin failures++; $display("FAIL reset_async obs=%h exp=0", obs()); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL reset_hold obs=%h exp=%h", obs(), mdl()); end
        @(negedge clk); rst_n = 1'b1;
        step(0, 1, 0, 0);   // vld while IDLE: ignored
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL idle_vld obs=%h exp=%h", obs(), mdl()); end
    endtask

    task automatic test_all_pass();
        int p[NVEC];
        shuffle(p);
        step(1, 0, 0, 0);
        checks++;
        if (obs() !== mdl() || busy !== 1'b1) begin failures++; $display("FAIL start obs=%h exp=%h", obs(), mdl()); end
        for (int i = 0; i < NVEC; i++) begin
            step(0, 1, p[i], 0);
            checks++;
            if (obs() !== mdl()) begin failures++; $display("FAIL all_pass[%0d] obs=%h exp=%h", i, obs(), mdl()); end
        end
        checks++;
        if ({done, pass, err_cnt} !== {2'b11, {ERR_W{1'b0}}}) begin
            failures++; $display("FAIL all_pass_end done=%b pass=%b err=%0d exp 1/1/0", done, pass, err_cnt);
        end
        step(0, 1, 3, 1);   // wrong response in DONE: nothing moves
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL done_hold obs=%h exp=%h", obs(), mdl()); end
    endtask

    task automatic test_one_fail();
        int p[NVEC];
        shuffle(p);
        step(1, 0, 0, 0);
        for (int i = 0; i < NVEC; i++) begin
            step(0, 1, p[i], p[i] == 3);
            checks++;
            if (obs() !== mdl()) begin failures++; $display("FAIL one_fail[%0d] obs=%h exp=%h", i, obs(), mdl()); end
        end
`ifndef CHK_STOP_ON_FAIL_EN
        checks++;
        if ({done, pass, err_cnt, first_fail_vld, first_fail_vec} !== {2'b10, ERR_W'(1), 1'b1, VW'(3)}) begin
            failures++;
            $display("FAIL one_fail_end done=%b pass=%b err=%0d ffv=%b vec=%0d exp 1/0/1/1/3",
                     done, pass, err_cnt, first_fail_vld, first_fail_vec);
        end
`endif
    endtask

    task automatic test_duplicates();
        step(1, 0, 0, 0);
        repeat (4) begin
            step(0, 1, 5, 0);
            checks++;
            if (obs() !== mdl()) begin failures++; $display("FAIL dup5 obs=%h exp=%h", obs(), mdl()); end
        end
        for (int v = 0; v < NVEC; v++) begin
            if (v == 5) continue;
            step(0, 1, v, 0);
            checks++;
            if (obs() !== mdl()) begin failures++; $display("FAIL dup_rest[%0d] obs=%h exp=%h", v, obs(), mdl()); end
        end
    endtask

    task automatic test_start_vld();
        step(1, 1, 0, 1);   // vector 0, wrong, with start: must be dropped
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL start_vld obs=%h exp=%h", obs(), mdl()); end
        for (int v = 1; v < NVEC; v++) step(0, 1, v, 0);
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL start_vld_7 obs=%h exp=%h", obs(), mdl()); end
        step(0, 1, 0, 0);
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL start_vld_8 obs=%h exp=%h", obs(), mdl()); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0);
        for (int v = 0; v < 4; v++) step(0, 1, v, v == 1);
        @(negedge clk);
        start = 0; vld = 0; rst_n = 1'b0;
        m_state = M_IDLE; model_clear();
        #1;
        checks++;
        if (obs() !== {SW{1'b0}}) begin failures++; $display("FAIL reset_mid obs=%h exp=0", obs()); end
        @(negedge clk); rst_n = 1'b1;
        step(1, 0, 0, 0);
        for (int v = NVEC-1; v >= 0; v--) begin
            step(0, 1, v, 0);
            checks++;
            if (obs() !== mdl()) begin failures++; $display("FAIL reset_rerun[%0d] obs=%h exp=%h", v, obs(), mdl()); end
        end
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0);
        repeat (ERRMAX + 40) step(0, 1, 6, 1);
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL saturate obs=%h exp=%h", obs(), mdl()); end
`ifndef CHK_STOP_ON_FAIL_EN
        checks++;
        if (err_cnt !== ERR_W'(ERRMAX)) begin failures++; $display("FAIL saturate_max err=%0d exp=%0d", err_cnt, ERRMAX); end
`endif
    endtask

`ifdef CHK_STOP_ON_FAIL_EN
    task automatic test_halt();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 2, 1);
        checks++;
        if ({done, pass, err_cnt} !== {2'b10, ERR_W'(1)}) begin
            failures++; $display("FAIL halt done=%b pass=%b err=%0d exp 1/0/1", done, pass, err_cnt);
        end
        for (int v = 3; v < NVEC; v++) step(0, 1, v, v[0]);
        checks++;
        if (obs() !== mdl()) begin failures++; $display("FAIL halt_hold obs=%h exp=%h", obs(), mdl()); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit st, v, bad;
            st  = ($urandom_range(0, 24) == 0);
            v   = ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 9) == 0);
            step(st, v, $urandom_range(0, NVEC-1), bad);
            checks++;
            if (obs() !== mdl()) begin failures++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs(), mdl()); end
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_one_fail();
        test_duplicates();
        test_start_vld();
        test_reset_mid();
        test_saturate();
`ifdef CHK_STOP_ON_FAIL_EN
        test_halt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_resp_checker.md
ADDER_RESP_CHECKER -- requirements
Module: adder_resp_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning operand width of the adder under check (legal 1..3).
REQ-002 SHALL have parameter ERR_W, default 8, meaning width of the mismatch counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that clears results and begins a check run.
REQ-006 SHALL have port vld  input  1  the current a/b/cin/s/cout sample is valid for checking.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands applied to the adder.
REQ-008 SHALL have port cin  input  1  carry-in applied to the adder.
REQ-009 SHALL have ports s  input  WIDTH and cout  input  1  adder response under check.
REQ-010 SHALL have port busy  output  1  high in the RUN state.
REQ-011 SHALL have port done  output  1  high in the DONE state (and HALT when enabled).
REQ-012 SHALL have port pass  output  1  done high and err_cnt equal to zero.
REQ-013 SHALL have port err_cnt  output  ERR_W  number of mismatching vectors.
REQ-014 SHALL have port first_fail_vld  output  1  first_fail_vec holds a captured failure.
REQ-015 SHALL have port first_fail_vec  output  2*WIDTH+1  {a,b,cin} of the first mismatch.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE (plus HALT per REQ-029).
REQ-017 SHALL move IDLE->RUN, DONE->RUN, HALT->RUN on start; start in RUN restarts the run in place.
REQ-018 SHALL, on start, clear err_cnt, first_fail_vld, first_fail_vec and the coverage bitmap.
REQ-019 SHALL ignore vld in the cycle start is high (start wins; sample discarded).
REQ-020 SHALL ignore vld outside RUN.
REQ-021 SHALL compute expected {cout,s} = a + b + cin at WIDTH+1 bits and compare to the sampled {cout,s}.
REQ-022 SHALL register the result: a vld sample in cycle N updates err_cnt, first_fail_* and coverage visible in cycle N+1.
REQ-023 SHALL saturate err_cnt at all-ones; no wrap.
REQ-024 SHALL capture first_fail_vec only on the first mismatch of a run; later mismatches leave it unchanged.
REQ-025 SHALL keep a 2^(2*WIDTH+1)-bit coverage bitmap indexed by {a,b,cin}; duplicate vectors are checked and counted but do not change coverage.
REQ-026 SHALL enter DONE in the same edge that registers the vector completing coverage, so done is visible in cycle N+1.
REQ-027 SHALL hold all outputs stable in DONE until start or reset.

Reset
REQ-028 SHALL, while rst_n is low, force state IDLE, busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0, first_fail_vec=0 and clear coverage; reset mid-run discards the run; no output change until the first clk edge after rst_n rises.

Configuration
REQ-029 SHALL support macro CHK_STOP_ON_FAIL_EN: defined -> the first mismatch moves RUN->HALT on the registering edge (done=1, pass=0, err_cnt=1, further vld ignored); undefined -> HALT absent and mismatches only count while the run continues to coverage.

Verification
REQ-030 SHALL cover: reset, start, the 8 vectors {a,b,cin}=0..7 with correct s/cout -> done=1 one cycle after the 8th vld, pass=1, err_cnt=0.
REQ-031 SHALL cover: vector 3'b011 driven with cout=0 (macro off) -> err_cnt=1, first_fail_vec=3'b011, first_fail_vld=1, done after full coverage, pass=0.
REQ-032 SHALL cover: vector 5 repeated 4 times, then the rest -> done only after all 8 distinct vectors; err_cnt=0.
REQ-033 SHALL cover: start and vld in the same cycle -> that vector not checked and not covered.
REQ-034 SHALL cover: rst_n pulsed low after 4 vectors -> all outputs zero immediately, IDLE; a new start then requires all 8 vectors again.
REQ-035 SHALL cover: with CHK_STOP_ON_FAIL_EN defined, a mismatch on vector 2 -> next cycle done=1, pass=0, err_cnt=1; subsequent vld ignored.
